// File: rtl/ivc_pkg.sv
// Shared types and constants for the IV bus controller.
// Optional timeout watchdog is enabled with the IVC_TIMEOUT_EN macro.
package ivc_pkg;

    localparam int unsigned IVC_DATA_W          = 8;
    localparam int unsigned IVC_ADDR_W          = 9;
    localparam int unsigned IVC_TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } ivc_state_e;

    typedef enum logic {
        BANK_L = 1'b0,
        BANK_R = 1'b1
    } ivc_bank_e;

    typedef struct packed {
        ivc_bank_e             bank;
        logic [IVC_DATA_W-1:0] addr;
        logic [IVC_DATA_W-1:0] data;
    } ivc_wr_s;

    // Logical bit i <-> pin 7-i, inverted; the mapping is its own inverse.
    function automatic logic [IVC_DATA_W-1:0] iv_map(input logic [IVC_DATA_W-1:0] v);
        logic [IVC_DATA_W-1:0] r;
        for (int i = 0; i < int'(IVC_DATA_W); i++) begin
            r[IVC_DATA_W-1-i] = ~v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/ivc_bank.sv
// One CPU bank: address latch, read buffer, valid bit and refresh-pending flag.
module ivc_bank
    import ivc_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  latch_i,
    input  logic [IVC_DATA_W-1:0] addr_i,
    input  logic                  start_i,
    input  logic                  load_i,
    input  logic [IVC_DATA_W-1:0] data_i,
    input  logic                  mark_i,
    input  logic                  drop_i,
    output logic [IVC_DATA_W-1:0] addr_o,
    output logic [IVC_DATA_W-1:0] rbuf_o,
    output logic                  valid_o,
    output logic                  pending_o
);

    logic [IVC_DATA_W-1:0] addr_q, addr_d;
    logic [IVC_DATA_W-1:0] rbuf_q, rbuf_d;
    logic                  valid_q, valid_d;
    logic                  pend_q, pend_d;
    logic                  dirty_q, dirty_d;

    // dirty marks a re-latch since the current fetch started, so its data is stale.
    always_comb begin
        addr_d  = addr_q;
        rbuf_d  = rbuf_q;
        valid_d = valid_q;
        pend_d  = pend_q;
        dirty_d = dirty_q;
        if (latch_i) begin
            addr_d  = addr_i;
            valid_d = 1'b0;
            pend_d  = 1'b1;
            dirty_d = 1'b1;
        end else begin
            if (start_i) begin
                dirty_d = 1'b0;
            end
            if (load_i && !dirty_q) begin
                rbuf_d  = data_i;
                valid_d = 1'b1;
                pend_d  = 1'b0;
            end
            if (mark_i) begin
                pend_d = 1'b1;
            end
            if (drop_i) begin
                pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q  <= '0;
            rbuf_q  <= '0;
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
            dirty_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            rbuf_q  <= rbuf_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
            dirty_q <= dirty_d;
        end
    end

    assign addr_o    = addr_q;
    assign rbuf_o    = rbuf_q;
    assign valid_o   = valid_q;
    assign pending_o = pend_q;

endmodule

// File: rtl/iv_bus_ctrl.sv
// Bridges the CPU IV bus to a request/ack device port with per-bank read buffers.
// Define IVC_TIMEOUT_EN to abort device requests left unacked for TIMEOUT_CYCLES.
module iv_bus_ctrl
    import ivc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = IVC_TIMEOUT_DEFAULT
) (
    input  logic                  x1,
    input  logic                  reset,
    input  logic                  sc,
    input  logic                  wc,
    input  logic                  mclk,
    input  logic                  lb_n,
    input  logic                  rb_n,
    input  logic [IVC_DATA_W-1:0] iv_in,
    output logic [IVC_DATA_W-1:0] iv_out,
    output logic                  iv_oe,
    output logic                  dev_req,
    output logic                  dev_we,
    output logic [IVC_ADDR_W-1:0] dev_addr,
    output logic [IVC_DATA_W-1:0] dev_wdata,
    input  logic [IVC_DATA_W-1:0] dev_rdata,
    input  logic                  dev_ack,
    output logic                  err_ovf,
    output logic                  err_stale,
    output logic                  err_tmo
);

    ivc_state_e            state_q, state_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [IVC_ADDR_W-1:0] addr_q, addr_d;
    logic [IVC_DATA_W-1:0] wdata_q, wdata_d;
    ivc_wr_s               wr_q, wr_d;
    logic                  wr_full_q, wr_full_d;
    logic                  ovf_q, ovf_d;
    logic                  stale_q, stale_d;

    logic [IVC_DATA_W-1:0] iv_log, addr_l, addr_r, rbuf_l, rbuf_r;
    logic                  valid_l, valid_r, pend_l, pend_r;
    logic                  latch_l, latch_r, wr_post;
    logic                  start_l, start_r, done, tmo_hit, tmo_expire;
    logic                  sel_valid;
    logic [IVC_DATA_W-1:0] sel_rbuf;
    ivc_bank_e             op_bank;

    assign iv_log  = iv_map(iv_in);
    assign latch_l = mclk & sc & ~lb_n;
    assign latch_r = mclk & sc & ~rb_n;
    assign wr_post = mclk & wc & ~sc & (~lb_n | ~rb_n);
    assign op_bank = ivc_bank_e'(addr_q[IVC_ADDR_W-1]);

    // Read drive: lb_n high here implies rb_n low, so lb_n selects the right bank.
    assign iv_oe     = reset & ~sc & ~wc & ~mclk & (lb_n ^ rb_n);
    assign sel_valid = lb_n ? valid_r : valid_l;
    assign sel_rbuf  = lb_n ? rbuf_r : rbuf_l;
    assign iv_out    = iv_map((iv_oe && sel_valid) ? sel_rbuf : IVC_DATA_W'(0));

    ivc_bank u_bank_l (
        .clk       (x1),
        .rst_n     (reset),
        .latch_i   (latch_l),
        .addr_i    (iv_log),
        .start_i   (start_l),
        .load_i    (done && state_q == ST_RD && op_bank == BANK_L),
        .data_i    (dev_rdata),
        .mark_i    (done && state_q == ST_WR && op_bank == BANK_L),
        .drop_i    (tmo_hit && state_q == ST_RD && op_bank == BANK_L),
        .addr_o    (addr_l),
        .rbuf_o    (rbuf_l),
        .valid_o   (valid_l),
        .pending_o (pend_l)
    );

    ivc_bank u_bank_r (
        .clk       (x1),
        .rst_n     (reset),
        .latch_i   (latch_r),
        .addr_i    (iv_log),
        .start_i   (start_r),
        .load_i    (done && state_q == ST_RD && op_bank == BANK_R),
        .data_i    (dev_rdata),
        .mark_i    (done && state_q == ST_WR && op_bank == BANK_R),
        .drop_i    (tmo_hit && state_q == ST_RD && op_bank == BANK_R),
        .addr_o    (addr_r),
        .rbuf_o    (rbuf_r),
        .valid_o   (valid_r),
        .pending_o (pend_r)
    );

    // Sequencer: pending write first, then left refresh, then right refresh.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        start_l = 1'b0;
        start_r = 1'b0;
        done    = 1'b0;
        tmo_hit = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (wr_full_q) begin
                    state_d = ST_WR;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = {wr_q.bank, wr_q.addr};
                    wdata_d = wr_q.data;
                end else if (pend_l) begin
                    state_d = ST_RD;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = {BANK_L, addr_l};
                    start_l = 1'b1;
                end else if (pend_r) begin
                    state_d = ST_RD;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = {BANK_R, addr_r};
                    start_r = 1'b1;
                end
            end
            ST_WR, ST_RD: begin
                if (dev_ack) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end else if (tmo_expire) begin
                    tmo_hit = 1'b1;
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Single write slot; a write arriving while it is occupied is dropped.
    always_comb begin
        wr_d      = wr_q;
        wr_full_d = wr_full_q;
        if ((done || tmo_hit) && state_q == ST_WR) begin
            wr_full_d = 1'b0;
        end
        if (wr_post && !wr_full_q) begin
            wr_full_d  = 1'b1;
            wr_d.bank  = ivc_bank_e'(lb_n);
            wr_d.addr  = lb_n ? addr_r : addr_l;
            wr_d.data  = iv_log;
        end
        ovf_d   = ovf_q | (wr_post & wr_full_q);
        stale_d = stale_q | (iv_oe & ~sel_valid);
    end

    always_ff @(posedge x1) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= '0;
            wr_full_q <= 1'b0;
            ovf_q     <= 1'b0;
            stale_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            wr_full_q <= wr_full_d;
            ovf_q     <= ovf_d;
            stale_q   <= stale_d;
        end
    end

`ifdef IVC_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_err_q;

    // Counter restarts on every IDLE cycle, so it measures the current request only.
    assign tmo_expire = (state_q != ST_IDLE) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign tmo_cnt_d  = (state_q == ST_IDLE) ? '0 : tmo_cnt_q + TMO_W'(1);

    always_ff @(posedge x1) begin
        if (!reset) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            if (tmo_hit) begin
                tmo_err_q <= 1'b1;
            end
        end
    end

    assign err_tmo = tmo_err_q;
`else
    logic unused_tmo_cfg;

    assign unused_tmo_cfg = |TIMEOUT_CYCLES;
    assign tmo_expire     = 1'b0;
    assign err_tmo        = 1'b0;
`endif

    assign dev_req   = req_q;
    assign dev_we    = we_q;
    assign dev_addr  = addr_q;
    assign dev_wdata = wdata_q;
    assign err_ovf   = ovf_q;
    assign err_stale = stale_q;

endmodule
